adc_capture_ctrl: RTL and testbench



---
 rtl/adc_capture_ctrl.sv | 164 ++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: triggered capture sequencer feeding the narrow write port
// of the capture RAM. It writes a circular pre-trigger history, waits for a
// qualified trigger, writes the post-trigger samples and then freezes.
// Optional feature: define ADC_CAPTURE_TEST_PATTERN_EN to add the testPattern
// port, which replaces sample data with a ramp counter.
module adc_capture_ctrl #(
  parameter int DATA_WIDTH    = 14,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     arm,
  input  logic [ADDRESS_WIDTH-1:0] pretrigCount,
  input  logic [ADDRESS_WIDTH:0]   postCount,
  input  logic                     trigger,
  input  logic                     sampleValid,
  input  logic [DATA_WIDTH-1:0]    sampleData,
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
  input  logic                     testPattern,
`endif
  output logic                     wEnable,
  output logic [ADDRESS_WIDTH-1:0] wAddr,
  output logic [DATA_WIDTH-1:0]    wData,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] triggerAddr,
  output logic [ADDRESS_WIDTH-1:0] startAddr
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRETRIG   = 3'd1,
    WAIT_TRIG = 3'd2,
    POSTTRIG  = 3'd3,
    DONE      = 3'd4
  } captureState_t;

  captureState_t state;

  logic [ADDRESS_WIDTH-1:0] preLatched;
  logic [ADDRESS_WIDTH:0]   postLatched;
  logic [ADDRESS_WIDTH-1:0] sampleCount;
  logic [ADDRESS_WIDTH-1:0] postCounter;
  logic [ADDRESS_WIDTH-1:0] addrNext;

  logic [ADDRESS_WIDTH:0]   postMin;
  logic [ADDRESS_WIDTH:0]   postLimit;
  logic [ADDRESS_WIDTH:0]   postArm;
  logic                     capturing;
  logic                     doWrite;
  logic [DATA_WIDTH-1:0]    sampleSel;

  // Post length seen at arm time: at least the trigger sample itself, and never
  // longer than the room left in the buffer after the pre-trigger history.
  assign postMin   = (postCount == '0) ? (ADDRESS_WIDTH+1)'(1) : postCount;
  assign postLimit = {1'b1, {ADDRESS_WIDTH{1'b0}}} - {1'b0, pretrigCount};
  assign postArm   = (postMin > postLimit) ? postLimit : postMin;

  // A write happens for every valid sample while a capture is running; an arm
  // in the same cycle aborts and takes priority over the sample.
  assign capturing = (state == PRETRIG) || (state == WAIT_TRIG) || (state == POSTTRIG);
  assign doWrite   = sampleValid && capturing && !arm;

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
  logic [DATA_WIDTH-1:0] rampCount;

  // Ramp source: restarts at zero on arm and advances once per written sample.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rampCount <= '0;
    end else if (arm) begin
      rampCount <= '0;
    end else if (doWrite) begin
      rampCount <= rampCount + 1'b1;
    end
  end

  assign sampleSel = testPattern ? rampCount : sampleData;
`else
  assign sampleSel = sampleData;
`endif

  // Registered RAM write port and the free-running circular write address.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wEnable  <= 1'b0;
      wAddr    <= '0;
      wData    <= '0;
      addrNext <= '0;
    end else begin
      wEnable <= doWrite;
      if (arm) begin
        addrNext <= '0;
      end else if (doWrite) begin
        wAddr    <= addrNext;
        wData    <= sampleSel;
        addrNext <= addrNext + 1'b1;
      end
    end
  end

  // Capture sequencer: pre-trigger count, trigger qualification, post count.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      preLatched  <= '0;
      postLatched <= '0;
      sampleCount <= '0;
      postCounter <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      triggerAddr <= '0;
      startAddr   <= '0;
    end else if (arm) begin
      preLatched  <= pretrigCount;
      postLatched <= postArm;
      sampleCount <= '0;
      postCounter <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      state       <= (pretrigCount == '0) ? WAIT_TRIG : PRETRIG;
    end else begin
      case (state)
        PRETRIG: begin
          if (sampleValid) begin
            sampleCount <= sampleCount + 1'b1;
            if (sampleCount == preLatched - 1'b1) begin
              state <= WAIT_TRIG;
            end
          end
        end
        WAIT_TRIG: begin
          if (sampleValid && trigger) begin
            triggerAddr <= addrNext;
            startAddr   <= addrNext - preLatched;
            // Low bits only: a full-buffer post length wraps to all ones.
            postCounter <= postLatched[ADDRESS_WIDTH-1:0] - 1'b1;
            if (postLatched == (ADDRESS_WIDTH+1)'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= POSTTRIG;
            end
          end
        end
        POSTTRIG: begin
          if (sampleValid) begin
            postCounter <= postCounter - 1'b1;
            if (postCounter == ADDRESS_WIDTH'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Testbench for adc_capture_ctrl with a small address space so that wrap and
// clamp cases stay short. Random data, duty cycle and stray triggers are
// checked against a record model computed from sample indices.
module tb_adc_capture_ctrl;
  localparam int DW    = 14;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          arm = 1'b0;
  logic [AW-1:0] pretrigCount = '0;
  logic [AW:0]   postCount = '0;
  logic          trigger = 1'b0;
  logic          sampleValid = 1'b0;
  logic [DW-1:0] sampleData = '0;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
  logic          testPattern = 1'b0;
`endif
  logic          wEnable;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] wData;
  logic          busy;
  logic          done;
  logic [AW-1:0] triggerAddr;
  logic [AW-1:0] startAddr;

  always #5 clk = ~clk;

  adc_capture_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .arm          (arm),
    .pretrigCount (pretrigCount),
    .postCount    (postCount),
    .trigger      (trigger),
    .sampleValid  (sampleValid),
    .sampleData   (sampleData),
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    .testPattern  (testPattern),
`endif
    .wEnable      (wEnable),
    .wAddr        (wAddr),
    .wData        (wData),
    .busy         (busy),
    .done         (done),
    .triggerAddr  (triggerAddr),
    .startAddr    (startAddr)
  );

  int compareCount  = 0;
  int mismatchCount = 0;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Observed RAM writes, sampled away from the active edge.
  int obsAddr[$];
  int obsData[$];
  int obsDone[$];

  always @(negedge clk) begin
    if (wEnable === 1'b1) begin
      obsAddr.push_back(int'(wAddr));
      obsData.push_back(int'(wData));
      obsDone.push_back(int'(done));
    end
  end

  task automatic checkAllZero(input string tag);
    checkValue({tag, ".wEnable"}, 32'(wEnable), 0);
    checkValue({tag, ".wAddr"}, 32'(wAddr), 0);
    checkValue({tag, ".wData"}, 32'(wData), 0);
    checkValue({tag, ".busy"}, 32'(busy), 0);
    checkValue({tag, ".done"}, 32'(done), 0);
    checkValue({tag, ".triggerAddr"}, 32'(triggerAddr), 0);
    checkValue({tag, ".startAddr"}, 32'(startAddr), 0);
  endtask

  // One capture: build stimulus, derive the expected record, drive, compare.
  // With doCheck = 0 the capture is cut short after maxCycles (abort/reset use).
  task automatic runCapture(input string name, input int pre, input int post, input int trigSample,
                            input int dutyMode, input bit earlyTrig, input bit armCollide,
                            input bit doCheck, input int maxCycles);
    int stimV[$];
    int stimT[$];
    int stimD[$];
    int expAddr[$];
    int expData[$];
    int postEff;
    int validCount;
    int k;
    int s;
    int endIdx;
    int nCycles;
    int nCmp;

    postEff = (post == 0) ? 1 : post;
    if (postEff > DEPTH - pre) postEff = DEPTH - pre;

    validCount = 0;
    for (int c = 0; c < 3000 && validCount <= trigSample + postEff + 2; c++) begin
      int v;
      int t;
      if (dutyMode == 0) v = 1;
      else if (dutyMode == 1) v = (c % 3 == 0) ? 1 : 0;
      else v = int'($urandom_range(0, 1));
      if (v == 1) begin
        if (validCount == trigSample) t = 1;
        else if (validCount < pre && earlyTrig) t = int'($urandom_range(0, 1));
        else if (validCount > trigSample) t = int'($urandom_range(0, 1));
        else t = 0;
      end else begin
        t = int'($urandom_range(0, 1));
      end
      stimV.push_back(v);
      stimT.push_back(t);
      stimD.push_back(int'($urandom_range(0, (1 << DW) - 1)));
      validCount += v;
    end

    // Trigger sample: first valid sample with trigger once the history is full.
    k = -1;
    s = 0;
    foreach (stimV[c]) begin
      if (stimV[c] == 1) begin
        if (k < 0 && stimT[c] == 1 && s >= pre) k = s;
        s++;
      end
    end
    endIdx = k + postEff - 1;
    s = 0;
    foreach (stimV[c]) begin
      if (stimV[c] == 1) begin
        if (s <= endIdx) begin
          expAddr.push_back(s % DEPTH);
          expData.push_back(stimD[c]);
        end
        s++;
      end
    end

    @(posedge clk); #1;
    arm          = 1'b1;
    pretrigCount = AW'(pre);
    postCount    = (AW+1)'(post);
    trigger      = armCollide;
    sampleValid  = armCollide ? 1'b1 : 1'($urandom_range(0, 1));
    sampleData   = DW'($urandom_range(0, (1 << DW) - 1));

    nCycles = doCheck ? stimV.size() : maxCycles;
    for (int c = 0; c < nCycles; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        obsAddr.delete();
        obsData.delete();
        obsDone.delete();
        if (doCheck) begin
          checkValue({name, ".busyAfterArm"}, 32'(busy), 1);
          checkValue({name, ".doneAfterArm"}, 32'(done), 0);
        end
      end
      arm         = 1'b0;
      sampleValid = stimV[c][0];
      trigger     = stimT[c][0];
      sampleData  = DW'(stimD[c]);
    end
    if (!doCheck) return;

    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      sampleValid = 1'b0;
      trigger     = 1'b0;
    end
    @(negedge clk);

    checkValue({name, ".writeCount"}, 32'(obsAddr.size()), 32'(expAddr.size()));
    nCmp = (obsAddr.size() < expAddr.size()) ? obsAddr.size() : expAddr.size();
    for (int i = 0; i < nCmp; i++) begin
      checkValue($sformatf("%s.wAddr[%0d]", name, i), 32'(obsAddr[i]), 32'(expAddr[i]));
      checkValue($sformatf("%s.wData[%0d]", name, i), 32'(obsData[i]), 32'(expData[i]));
      checkValue($sformatf("%s.doneAtWrite[%0d]", name, i), 32'(obsDone[i]),
                 (i == expAddr.size() - 1) ? 1 : 0);
    end
    checkValue({name, ".triggerAddr"}, 32'(triggerAddr), 32'(k % DEPTH));
    checkValue({name, ".startAddr"}, 32'(startAddr), 32'((k - pre) % DEPTH));
    checkValue({name, ".doneFinal"}, 32'(done), 1);
    checkValue({name, ".busyFinal"}, 32'(busy), 0);
    $display("capture %s: pre=%0d post=%0d trigSample=%0d writes=%0d/%0d triggerAddr=%0d startAddr=%0d",
             name, pre, post, k, obsAddr.size(), expAddr.size(), triggerAddr, startAddr);
  endtask

  initial begin
    #2;
    checkAllZero("reset");
    @(posedge clk); #1;
    resetN = 1'b1;
    $display("reset released");

    runCapture("baseline", 4, 8, 9, 0, 1'b0, 1'b0, 1'b1, 0);
    runCapture("earlyTrig", 12, 3, 20, 0, 1'b1, 1'b0, 1'b1, 0);
    runCapture("wrap", 6, 7, 40, 0, 1'b0, 1'b0, 1'b1, 0);
    runCapture("pre0post0", 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 0);
    runCapture("clamp", 3, DEPTH, 3, 0, 1'b0, 1'b0, 1'b1, 0);

    // Abort in POSTTRIG, then a fresh record must start at address 0.
    runCapture("abortRun", 2, 10, 4, 0, 1'b0, 1'b0, 1'b0, 8);
    runCapture("rearm", 5, 6, 11, 0, 1'b0, 1'b0, 1'b1, 0);

    runCapture("gapped", 5, 9, 13, 1, 1'b1, 1'b0, 1'b1, 0);
    runCapture("armCollide", 0, 4, 3, 0, 1'b0, 1'b1, 1'b1, 0);

    // Asynchronous reset in the middle of a capture.
    runCapture("resetRun", 3, 8, 6, 0, 1'b0, 1'b0, 1'b0, 7);
    #3;
    resetN = 1'b0;
    #1;
    checkAllZero("midReset");
    $display("mid-capture reset applied");
    @(posedge clk); #1;
    resetN = 1'b1;

    for (int r = 0; r < 4; r++) begin
      int pre;
      pre = int'($urandom_range(0, DEPTH - 1));
      runCapture($sformatf("random%0d", r), pre, int'($urandom_range(0, DEPTH)),
                 pre + int'($urandom_range(0, 20)), 2, 1'b1, 1'b0, 1'b1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
